platform_clkgen: RTL and testbench
==================================

PLATFORM_CLKGEN -- requirements
Module: platform_clkgen

Interface
REQ-001 SHALL have parameter NUM_CLKS, default 2, number of output clock channels (1..8).
REQ-002 SHALL have parameter CNT_W, default 16, width of divisor and phase fields.
REQ-003 SHALL have parameter LOCK_CYCLES, default 1024, settle time in refclk cycles before lock (>=1).
REQ-004 SHALL have parameter DEFAULT_DIV, default 2, reset divisor of every channel.
REQ-005 SHALL have port refclk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port cfg_we  input  1  configuration write strobe.
REQ-008 SHALL have port cfg_sel  input  $clog2(NUM_CLKS) (min 1)  channel being written.
REQ-009 SHALL have port cfg_div  input  CNT_W  divisor D for the selected channel.
REQ-010 SHALL have port cfg_phase  input  CNT_W  phase offset P, in refclk cycles.
REQ-011 SHALL have port cfg_ready  output  1  high when a write will be accepted.
REQ-012 SHALL have port outclk  output  NUM_CLKS  registered divided clocks, bit i = channel i.
REQ-013 SHALL have port outclk_stb  output  NUM_CLKS  one-cycle pulse on each outclk rising edge (macro-gated, see REQ-030).
REQ-014 SHALL have port locked  output  1  high when all channels run with the current configuration.

Function
REQ-015 SHALL implement states RESET, SETTLE, LOCKED; RESET is occupied only while rst=1.
REQ-016 SHALL move RESET->SETTLE on the first cycle with rst=0; SETTLE->LOCKED after exactly LOCK_CYCLES cycles in SETTLE.
REQ-017 SHALL hold each channel counter at its P during RESET and SETTLE, and force outclk, outclk_stb and locked to 0 there.
REQ-018 SHALL, in LOCKED, advance each counter cnt = (cnt==D-1) ? 0 : cnt+1 every cycle; the first LOCKED cycle uses cnt=P.
REQ-019 SHALL drive outclk[i] registered, high when cnt < floor(D/2), low otherwise (duty floor(D/2)/D).
REQ-020 SHALL pulse outclk_stb[i] for one cycle in the same cycle outclk[i] goes 0->1.
REQ-021 SHALL clamp writes with cfg_div < 2 to D=2, and cfg_phase >= D to P=D-1 (clamping on the stored value).
REQ-022 SHALL assert cfg_ready only in LOCKED; cfg_we with cfg_ready=0 is ignored with no effect.
REQ-023 SHALL, on an accepted write, store D/P for channel cfg_sel next cycle and enter SETTLE, dropping locked and all outclk next cycle; all channels then restart together, phase-aligned.
REQ-024 SHALL ignore writes with cfg_sel >= NUM_CLKS while still performing the SETTLE cycle.
REQ-025 SHALL give rst priority over a simultaneous cfg_we.
REQ-026 SHALL assert locked, registered, on the first LOCKED cycle; locked is high iff state is LOCKED.

Reset
REQ-027 SHALL on rst=1 set every channel to D=DEFAULT_DIV, P=0, counters to 0, settle counter to 0.
REQ-028 SHALL hold outclk=0, outclk_stb=0, locked=0, cfg_ready=0 during and on the cycle after rst.
REQ-029 SHALL abort any SETTLE in progress on rst and restart the full LOCK_CYCLES count after release.

Configuration
REQ-030 SHALL, with CLKGEN_STB_EN defined, include outclk_stb port and its logic; without it, port and logic SHALL be absent and all else unchanged.

Structure
REQ-031 SHALL place state enum, minimum divisor constant (2) and clamp function in package platform_clkgen_pkg.
REQ-032 SHALL implement one channel (counter, outclk, strobe) as sub-module platform_clkgen_chan, instantiated NUM_CLKS times.

Verification
REQ-033 SHALL cover: rst 1->0, LOCK_CYCLES=16 -> locked rises 16 cycles after first rst=0 cycle; outclk[0] toggles every cycle for D=2.
REQ-034 SHALL cover: write sel=1, D=5, P=0 -> locked drops next cycle, relocks after 16; outclk[1] pattern 1,1,0,0,0 repeating; stb once per 5.
REQ-035 SHALL cover: sel=0 D=4 P=0 and sel=1 D=4 P=2 -> outclk[1] lags outclk[0] by exactly 2 cycles.
REQ-036 SHALL cover: cfg_div=0, cfg_phase=9 -> stored D=2, P=1; cfg_we during SETTLE -> ignored, config unchanged.
REQ-037 SHALL cover: rst asserted 5 cycles into SETTLE with simultaneous cfg_we -> defaults restored, full 16-cycle settle repeated.

Source files
------------

// File: rtl/platform_clkgen_pkg.sv
// rtl/platform_clkgen_pkg.sv - shared types, constants and clamp helpers for platform_clkgen
// Contents: FSM state enum, minimum divisor constant, divisor/phase clamp functions.
// The clamp functions work on 32-bit values; callers cast to their own CNT_W (CNT_W <= 32).
package platform_clkgen_pkg;

  typedef enum logic [1:0] {
    ST_RESET  = 2'd0,
    ST_SETTLE = 2'd1,
    ST_LOCKED = 2'd2
  } clkgen_state_e;

  localparam int unsigned CLKGEN_MIN_DIV = 2;

  // Divisors below 2 cannot produce a high and a low phase, so they are raised to 2.
  function automatic logic [31:0] clkgen_clamp_div(input logic [31:0] div);
    return (div < 32'(CLKGEN_MIN_DIV)) ? 32'(CLKGEN_MIN_DIV) : div;
  endfunction

  // Phase must land inside the counter range of the already-clamped divisor.
  function automatic logic [31:0] clkgen_clamp_phase(input logic [31:0] phase,
                                                     input logic [31:0] div);
    return (phase >= div) ? (div - 32'd1) : phase;
  endfunction

endpackage

// File: rtl/platform_clkgen_if.sv
// rtl/platform_clkgen_if.sv - configuration write port for platform_clkgen
// Signals: cfg_we (write strobe), cfg_sel (channel), cfg_div (divisor D),
//          cfg_phase (phase P), cfg_ready (write will be accepted).
// Modports: master drives the write, slave is the clock generator.
interface platform_clkgen_if #(
  parameter int NUM_CLKS = 2,
  parameter int CNT_W    = 16
);
  localparam int SEL_W = (NUM_CLKS > 1) ? $clog2(NUM_CLKS) : 1;

  logic             cfg_we;
  logic [SEL_W-1:0] cfg_sel;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_phase;
  logic             cfg_ready;

  modport master (
    output cfg_we, cfg_sel, cfg_div, cfg_phase,
    input  cfg_ready
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_div, cfg_phase,
    output cfg_ready
  );

endinterface

// File: rtl/platform_clkgen_chan.sv
// rtl/platform_clkgen_chan.sv - one divided-clock channel: D/P storage, counter, outclk, strobe
// Optional feature macro: CLKGEN_STB_EN (adds outclk_stb).
// Ports: refclk/rst clock and sync active-high reset; load/load_div/load_phase store a
//        clamped configuration; run = next cycle is LOCKED; adv = counter free-runs this edge;
//        outclk registered divided clock; outclk_stb one-cycle pulse on outclk rising.
module platform_clkgen_chan #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 2
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_div,
  input  logic [CNT_W-1:0] load_phase,
  input  logic             run,
  input  logic             adv,
`ifdef CLKGEN_STB_EN
  output logic             outclk_stb,
`endif
  output logic             outclk
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             outclk_q, outclk_d;

  always_comb begin
    div_d   = load ? load_div : div_q;
    phase_d = load ? load_phase : phase_q;
    // Outside free-run the counter sits at P so the first LOCKED cycle starts from P,
    // which keeps every channel phase-aligned after each settle.
    if (adv) begin
      cnt_d = (cnt_q == div_q - ONE) ? '0 : cnt_q + ONE;
    end else begin
      cnt_d = phase_d;
    end
    // outclk is computed from the next counter value so the register lines up with cnt_q.
    outclk_d = run && (cnt_d < (div_q >> 1));
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      div_q    <= CNT_W'(DEFAULT_DIV);
      phase_q  <= '0;
      cnt_q    <= '0;
      outclk_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      phase_q  <= phase_d;
      cnt_q    <= cnt_d;
      outclk_q <= outclk_d;
    end
  end

  assign outclk = outclk_q;

`ifdef CLKGEN_STB_EN
  logic stb_q;

  always_ff @(posedge refclk) begin
    if (rst) begin
      stb_q <= 1'b0;
    end else begin
      stb_q <= outclk_d & ~outclk_q;
    end
  end

  assign outclk_stb = stb_q;
`endif

endmodule

// File: rtl/platform_clkgen.sv
// rtl/platform_clkgen.sv - multi-channel programmable divided-clock generator with lock FSM
// Optional feature macro: CLKGEN_STB_EN (adds outclk_stb port and strobe logic).
// Ports: refclk sole clock; rst sync active-high reset; cfg slave configuration port;
//        outclk per-channel divided clocks; outclk_stb per-channel rising-edge pulses;
//        locked high while every channel runs the current configuration.
module platform_clkgen
  import platform_clkgen_pkg::*;
#(
  parameter int NUM_CLKS    = 2,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 1024,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                refclk,
  input  logic                rst,
  platform_clkgen_if.slave    cfg,
  output logic [NUM_CLKS-1:0] outclk,
`ifdef CLKGEN_STB_EN
  output logic [NUM_CLKS-1:0] outclk_stb,
`endif
  output logic                locked
);

  localparam int SETTLE_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_CYCLES - 1);

  clkgen_state_e        state_q, state_d;
  logic [SETTLE_W-1:0]  settle_q, settle_d;
  logic                 accept;
  logic                 run;
  logic                 adv;
  logic [CNT_W-1:0]     load_div;
  logic [CNT_W-1:0]     load_phase;
  logic [NUM_CLKS-1:0]  load_vec;

  always_ff @(posedge refclk) begin
    if (rst) begin
      state_q  <= ST_RESET;
      settle_q <= '0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    accept   = 1'b0;
    unique case (state_q)
      ST_RESET: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
      end
      ST_SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = ST_LOCKED;
          settle_d = '0;
        end else begin
          settle_d = settle_q + SETTLE_W'(1);
        end
      end
      ST_LOCKED: begin
        // Any accepted write re-settles, even one addressed to a missing channel.
        if (cfg.cfg_we) begin
          accept   = 1'b1;
          state_d  = ST_SETTLE;
          settle_d = '0;
        end
      end
      default: begin
        state_d  = ST_RESET;
        settle_d = '0;
      end
    endcase
  end

  always_comb begin
    load_div   = CNT_W'(clkgen_clamp_div(32'(cfg.cfg_div)));
    load_phase = CNT_W'(clkgen_clamp_phase(32'(cfg.cfg_phase), 32'(load_div)));
    for (int i = 0; i < NUM_CLKS; i++) begin
      load_vec[i] = accept && (32'(cfg.cfg_sel) == i);
    end
  end

  assign run = (state_d == ST_LOCKED);
  assign adv = (state_q == ST_LOCKED) && run;

  for (genvar g = 0; g < NUM_CLKS; g++) begin : g_chan
    platform_clkgen_chan #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .refclk     (refclk),
      .rst        (rst),
      .load       (load_vec[g]),
      .load_div   (load_div),
      .load_phase (load_phase),
      .run        (run),
      .adv        (adv),
`ifdef CLKGEN_STB_EN
      .outclk_stb (outclk_stb[g]),
`endif
      .outclk     (outclk[g])
    );
  end

  assign locked        = (state_q == ST_LOCKED);
  assign cfg.cfg_ready = (state_q == ST_LOCKED);

endmodule

// File: tb/tb_platform_clkgen.sv
// tb/tb_platform_clkgen.sv - directed self-checking bench for platform_clkgen
// Optional feature macro: CLKGEN_STB_EN (strobe port connected and checked when defined).
module tb_platform_clkgen;

  localparam int NUM_CLKS    = 3;
  localparam int CNT_W       = 16;
  localparam int LOCK_CYCLES = 16;
  localparam int DEFAULT_DIV = 2;

  logic                refclk;
  logic                rst;
  logic [NUM_CLKS-1:0] outclk;
`ifdef CLKGEN_STB_EN
  logic [NUM_CLKS-1:0] outclk_stb;
`endif
  logic                locked;

  int n_checks;
  int n_fail;
  int n_wait;

  platform_clkgen_if #(.NUM_CLKS(NUM_CLKS), .CNT_W(CNT_W)) cfg_if ();

  platform_clkgen #(
    .NUM_CLKS    (NUM_CLKS),
    .CNT_W       (CNT_W),
    .LOCK_CYCLES (LOCK_CYCLES),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .cfg        (cfg_if),
    .outclk     (outclk),
`ifdef CLKGEN_STB_EN
    .outclk_stb (outclk_stb),
`endif
    .locked     (locked)
  );

  initial begin
    refclk = 1'b0;
    forever #5 refclk = ~refclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge refclk);
    @(negedge refclk);
  endtask

  task automatic do_write(input int sel, input int div, input int phase);
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_sel   = 2'(sel);
    cfg_if.cfg_div   = CNT_W'(div);
    cfg_if.cfg_phase = CNT_W'(phase);
    tick();
    cfg_if.cfg_we    = 1'b0;
  endtask

  task automatic wait_lock(output int n);
    n = 0;
    while (!locked && n < 64) begin
      tick();
      n++;
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst              = 1'b1;
    cfg_if.cfg_we    = 1'b0;
    cfg_if.cfg_sel   = '0;
    cfg_if.cfg_div   = '0;
    cfg_if.cfg_phase = '0;

    // Reset state
    tick();
    tick();
    check("rst_locked", 32'(locked), 32'd0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    check("rst_outclk", 32'(outclk), 32'd0);

    // Release: first rst=0 edge, then 16 settle cycles
    rst = 1'b0;
    tick();
    check("post_rst_locked", 32'(locked), 32'd0);
    check("post_rst_outclk", 32'(outclk), 32'd0);
    check("post_rst_ready", 32'(cfg_if.cfg_ready), 32'd0);
    wait_lock(n_wait);
    check("rst_lock_latency", 32'(n_wait), 32'd16);
    check("locked_ready", 32'(cfg_if.cfg_ready), 32'd1);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("d2_all_%0d", k), 32'(outclk), (k % 2 == 0) ? 32'd7 : 32'd0);
`ifdef CLKGEN_STB_EN
      check($sformatf("d2_stb_%0d", k), 32'(outclk_stb), (k % 2 == 0) ? 32'd7 : 32'd0);
`endif
      tick();
    end

    // sel=1 D=5 P=0
    do_write(1, 5, 0);
    check("wr_drop_locked", 32'(locked), 32'd0);
    check("wr_drop_outclk", 32'(outclk), 32'd0);
    check("wr_drop_ready", 32'(cfg_if.cfg_ready), 32'd0);
    wait_lock(n_wait);
    check("d5_lock_latency", 32'(n_wait), 32'd16);
    for (int k = 0; k < 10; k++) begin
      check($sformatf("d5_ch1_%0d", k), 32'(outclk[1]), (k % 5 < 2) ? 32'd1 : 32'd0);
      check($sformatf("d5_ch0_%0d", k), 32'(outclk[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
`ifdef CLKGEN_STB_EN
      check($sformatf("d5_stb1_%0d", k), 32'(outclk_stb[1]), (k % 5 == 0) ? 32'd1 : 32'd0);
`endif
      tick();
    end

    // sel=0 D=4 P=0 then sel=1 D=4 P=2: channel 1 trails channel 0 by two cycles
    do_write(0, 4, 0);
    wait_lock(n_wait);
    check("d4a_lock_latency", 32'(n_wait), 32'd16);
    do_write(1, 4, 2);
    wait_lock(n_wait);
    check("d4b_lock_latency", 32'(n_wait), 32'd16);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("ph_ch0_%0d", k), 32'(outclk[0]), (k % 4 < 2) ? 32'd1 : 32'd0);
      check($sformatf("ph_ch1_%0d", k), 32'(outclk[1]), ((k + 2) % 4 < 2) ? 32'd1 : 32'd0);
      tick();
    end

    // Clamp: cfg_div=0, cfg_phase=9 -> D=2, P=1
    do_write(0, 0, 9);
    wait_lock(n_wait);
    check("clamp_lock_latency", 32'(n_wait), 32'd16);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("clamp_ch0_%0d", k), 32'(outclk[0]), (k % 2 == 1) ? 32'd1 : 32'd0);
      tick();
    end

    // Write during SETTLE is ignored and does not restart the settle count
    do_write(0, 6, 0);
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_sel   = 2'd0;
    cfg_if.cfg_div   = CNT_W'(8);
    cfg_if.cfg_phase = CNT_W'(3);
    tick();
    cfg_if.cfg_we    = 1'b0;
    check("settle_we_locked", 32'(locked), 32'd0);
    wait_lock(n_wait);
    check("settle_we_latency", 32'(n_wait), 32'd15);
    for (int k = 0; k < 6; k++) begin
      check($sformatf("d6_ch0_%0d", k), 32'(outclk[0]), (k % 6 < 3) ? 32'd1 : 32'd0);
      tick();
    end

    // Reset 5 cycles into SETTLE, with a simultaneous write
    do_write(1, 7, 3);
    repeat (4) tick();
    rst              = 1'b1;
    cfg_if.cfg_we    = 1'b1;
    cfg_if.cfg_sel   = 2'd1;
    cfg_if.cfg_div   = CNT_W'(9);
    cfg_if.cfg_phase = CNT_W'(0);
    tick();
    rst           = 1'b0;
    cfg_if.cfg_we = 1'b0;
    check("rst2_locked", 32'(locked), 32'd0);
    check("rst2_ready", 32'(cfg_if.cfg_ready), 32'd0);
    check("rst2_outclk", 32'(outclk), 32'd0);
    tick();
    check("rst2_post_locked", 32'(locked), 32'd0);
    wait_lock(n_wait);
    check("rst2_lock_latency", 32'(n_wait), 32'd16);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rst2_pat_%0d", k), 32'(outclk), (k % 2 == 0) ? 32'd7 : 32'd0);
      tick();
    end

    // Out-of-range channel: settle still happens, configuration unchanged
    do_write(3, 5, 0);
    check("badsel_locked", 32'(locked), 32'd0);
    wait_lock(n_wait);
    check("badsel_latency", 32'(n_wait), 32'd16);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("badsel_pat_%0d", k), 32'(outclk), (k % 2 == 0) ? 32'd7 : 32'd0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
